shift_deser_rx: RTL and testbench

- Serial-in, parallel-out receiver for the serial stream produced by the N-bit left shift register (SO is its MSB, so the stream is MSB-first).
- Collects N bits framed by a start-of-frame strobe and presents each completed word on a valid/ready output port.
- Flags overrun and framing errors with sticky status bits.
- Sits at the far end of the serial link, feeding a parallel consumer.

---
 rtl/shift_deser_rx_if.sv | 17 +
 rtl/shift_deser_rx.sv | 132 +++++++++++++
 tb/tb_shift_deser_rx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/shift_deser_rx_if.sv
// Parallel word port of the serial receiver.
//   q        : received word, held stable while q_valid=1 and not consumed
//   q_valid  : q holds an unconsumed word
//   q_ready  : consumer accepts q when q_valid and q_ready are both 1 at a clk edge
// Handshake: a word moves on a rising clk edge where q_valid=1 and q_ready=1.
// The producer never changes q while q_valid=1 unless that same edge is an accept.
// q_ready has no effect while q_valid=0.
interface shift_deser_rx_if #(
  parameter int N = 8
);
  logic [N-1:0] q;
  logic         q_valid;
  logic         q_ready;

  modport master (output q, output q_valid, input q_ready);
  modport slave  (input q, input q_valid, output q_ready);
endinterface

// File: rtl/shift_deser_rx.sv
// Serial-in, parallel-out receiver for an MSB-first stream framed by sof.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active low
//   en         : bit strobe, SI/sof sampled only when en=1
//   SI         : serial data, MSB first
//   sof        : with en, marks the current SI bit as the word MSB
//   bus        : master side of the word port (q, q_valid, q_ready)
//   busy       : 1 while a frame is being received
//   overrun    : sticky, a completed word was dropped
//   frame_err  : sticky, a frame restarted over a partial word
//   err_clr    : synchronous clear of both sticky flags
//   state_o    : raw FSM state (0=IDLE, 1=RECV) for observation
module shift_deser_rx #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   SI,
  input  logic                   sof,
  shift_deser_rx_if.master       bus,
  output logic                   busy,
  output logic                   overrun,
  output logic                   frame_err,
  input  logic                   err_clr,
  output logic                   state_o
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   word_q, word_d;
  logic           valid_q, valid_d;
  logic           ovr_q, ovr_d;
  logic           ferr_q, ferr_d;

  logic [N-1:0]   shifted;
  logic           complete;
  logic           ferr_set;
  logic           ovr_set;

  assign shifted = {sr_q[N-2:0], SI};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Framing FSM: bit collection and word completion.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && sof) begin
          sr_d    = shifted;
          cnt_d   = CW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (en) begin
          sr_d = shifted;
          if (sof) begin
            // Restart: the partial word is abandoned, this bit is the new MSB.
            ferr_set = 1'b1;
            cnt_d    = CW'(1);
          end else if (cnt_q == CW'(N - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output word register and sticky flags.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (complete) begin
      // An accept on the same edge frees the slot for the new word.
      if (!valid_q || bus.q_ready) begin
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && bus.q_ready) begin
      valid_d = 1'b0;
    end
    // A set event on the same edge as err_clr keeps the flag set.
    ovr_d  = ovr_set  | (ovr_q  & ~err_clr);
    ferr_d = ferr_set | (ferr_q & ~err_clr);
  end

  assign bus.q       = word_q;
  assign bus.q_valid = valid_q;
  assign busy        = (state_q == RECV);
  assign overrun     = ovr_q;
  assign frame_err   = ferr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_shift_deser_rx.sv
module tb_shift_deser_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, si = 1'b0, sof = 1'b0, err_clr = 1'b0;
  logic busy, overrun, frame_err, state_o;

  shift_deser_rx_if #(.N(8)) dif ();

  shift_deser_rx #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .SI        (si),
    .sof       (sof),
    .bus       (dif),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr),
    .state_o   (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic       en, sof, si, rdy, clr;
    logic [7:0] eq;
    logic       ev, eb, eo, ef;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;
  int vec_no = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, vec_no, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic s, input logic d, input logic r, input logic c,
                     input logic [7:0] eq, input logic ev, input logic eb, input logic eo,
                     input logic ef);
    vec_t v;
    v.en = e; v.sof = s; v.si = d; v.rdy = r; v.clr = c;
    v.eq = eq; v.ev = ev; v.eb = eb; v.eo = eo; v.ef = ef;
    vq.push_back(v);
  endtask

  // One framed byte, MSB first. gap = idle en=0 cycles inserted after bit 4.
  // qb/vb: word port before completion; qa/va/oa: after the LSB edge.
  task automatic add_byte(input logic [7:0] b, input int gap, input logic rdy_last,
                          input logic clr_first, input logic [7:0] qb, input logic vb,
                          input logic o, input logic f, input logic [7:0] qa,
                          input logic va, input logic oa);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0)
        add(1'b1, 1'b0, b[i], rdy_last, 1'b0, qa, va, 1'b0, oa, f);
      else
        add(1'b1, (i == 7), b[i], 1'b0, (i == 7) && clr_first, qb, vb, 1'b1, o, f);
      if (i == 4)
        for (int g = 0; g < gap; g++)
          add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, qb, vb, 1'b1, o, f);
    end
  endtask

  task automatic run_table();
    vec_t v;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      @(negedge clk);
      en = v.en; sof = v.sof; si = v.si; dif.q_ready = v.rdy; err_clr = v.clr;
      @(posedge clk);
      #1;
      chk("q",         dif.q,     v.eq);
      chk("q_valid",   {7'd0, dif.q_valid}, {7'd0, v.ev});
      chk("busy",      {7'd0, busy},        {7'd0, v.eb});
      chk("overrun",   {7'd0, overrun},     {7'd0, v.eo});
      chk("frame_err", {7'd0, frame_err},   {7'd0, v.ef});
      vec_no++;
    end
    @(negedge clk);
    en = 1'b0; sof = 1'b0; si = 1'b0; dif.q_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q"},         dif.q, 8'h00);
    chk({tag, "_q_valid"},   {7'd0, dif.q_valid}, 8'h00);
    chk({tag, "_busy"},      {7'd0, busy},        8'h00);
    chk({tag, "_overrun"},   {7'd0, overrun},     8'h00);
    chk({tag, "_frame_err"}, {7'd0, frame_err},   8'h00);
    chk({tag, "_state"},     {7'd0, state_o},     8'h00);
  endtask

  // ---------------- test ----------------
  initial begin
    dif.q_ready = 1'b0;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // 1: A5, no back-pressure relief
    add_byte(8'hA5, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    // 2: 3C with a 3-cycle en gap between bits 4 and 5
    add_byte(8'h3C, 3, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    // 3: A5 left pending, 0F dropped -> overrun; consume; clear
    add_byte(8'hA5, 0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
    add_byte(8'h0F, 0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    // 4: 11 pending, ready on exactly the edge completing 22
    add_byte(8'h11, 0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0);
    add_byte(8'h22, 0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    // 5: bits without sof in IDLE are ignored
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    // 5: 3 bits of a frame, then restart with C3 -> frame_err
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    add_byte(8'hC3, 0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    // Partial frame, then restart coinciding with err_clr: set wins.
    // FF then completes against a pending C3 -> overrun.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    add_byte(8'hFF, 0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1);
    // 6: partial frame in flight before the asynchronous reset
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
    run_table();

    // Asynchronous reset between edges: outputs clear before the next edge.
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;

    add_byte(8'h5A, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    run_table();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
